// File: rtl/eval_core_ctrl_pkg.sv
// Shared definitions for the eval core control register block.
// Register word indices, AXI response codes and control FSM states.
// No logic; imported by the interface and top modules.
package eval_core_ctrl_pkg;

  localparam logic [2:0] ADR_ID      = 3'd0;
  localparam logic [2:0] ADR_CONTROL = 3'd1;
  localparam logic [2:0] ADR_STATUS  = 3'd2;
  localparam logic [2:0] ADR_SIZE    = 3'd3;
  localparam logic [2:0] ADR_CYCLES  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Word indices 5..7 have no register behind them.
  function automatic logic idx_mapped(input logic [2:0] idx);
    return idx <= ADR_CYCLES;
  endfunction

endpackage

// File: rtl/eval_core_ctrl_axi4l_if.sv
// AXI4-Lite slave front end: AW/W holding registers, B and R response channels.
// Latency: commit one edge after both AW and W are held; R registered at the AR handshake.
// Backpressure: AW/W stall while held; commit stalls while B is unconsumed; AR stalls while R is pending.
module eval_core_ctrl_axi4l_if
  import eval_core_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_axi4l_awaddr,
  input  logic [2:0]              s_axi4l_awprot,
  input  logic                    s_axi4l_awvalid,
  output logic                    s_axi4l_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi4l_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi4l_wstrb,
  input  logic                    s_axi4l_wvalid,
  output logic                    s_axi4l_wready,
  output logic [1:0]              s_axi4l_bresp,
  output logic                    s_axi4l_bvalid,
  input  logic                    s_axi4l_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi4l_araddr,
  input  logic [2:0]              s_axi4l_arprot,
  input  logic                    s_axi4l_arvalid,
  output logic                    s_axi4l_arready,
  output logic [DATA_WIDTH-1:0]   s_axi4l_rdata,
  output logic [1:0]              s_axi4l_rresp,
  output logic                    s_axi4l_rvalid,
  input  logic                    s_axi4l_rready,
  output logic                    wr_en,
  output logic [2:0]              wr_idx,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_en,
  output logic [2:0]              rd_idx,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_err
);

  logic                    aw_held, w_held;
  logic [2:0]              aw_idx_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    commit;

  // Protection bits and address bits outside [5:3] carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi4l_awprot, s_axi4l_arprot,
                              s_axi4l_awaddr[ADDR_WIDTH-1:6], s_axi4l_awaddr[2:0],
                              s_axi4l_araddr[ADDR_WIDTH-1:6], s_axi4l_araddr[2:0]};

  assign s_axi4l_awready = !aw_held;
  assign s_axi4l_wready  = !w_held;
  assign s_axi4l_arready = !s_axi4l_rvalid;

  // A write lands only once both halves are in and the previous response can be replaced.
  assign commit  = aw_held && w_held && (!s_axi4l_bvalid || s_axi4l_bready);
  assign wr_en   = commit;
  assign wr_idx  = aw_idx_q;
  assign wr_data = w_data_q;
  assign wr_strb = w_strb_q;

  assign rd_en   = s_axi4l_arvalid && s_axi4l_arready;
  assign rd_idx  = s_axi4l_araddr[5:3];

  // Write address holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
    end else if (commit) begin
      aw_held  <= 1'b0;
    end else if (s_axi4l_awvalid && s_axi4l_awready) begin
      aw_held  <= 1'b1;
      aw_idx_q <= s_axi4l_awaddr[5:3];
    end
  end

  // Write data holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      w_held   <= 1'b0;
    end else if (s_axi4l_wvalid && s_axi4l_wready) begin
      w_held   <= 1'b1;
      w_data_q <= s_axi4l_wdata;
      w_strb_q <= s_axi4l_wstrb;
    end
  end

  // Write response: raised at commit, held until the master takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_axi4l_bvalid <= 1'b0;
      s_axi4l_bresp  <= RESP_OKAY;
    end else if (commit) begin
      s_axi4l_bvalid <= 1'b1;
      s_axi4l_bresp  <= idx_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi4l_bready) begin
      s_axi4l_bvalid <= 1'b0;
    end
  end

  // Read response: snapshot of register state at the AR handshake, held until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_axi4l_rvalid <= 1'b0;
      s_axi4l_rdata  <= '0;
      s_axi4l_rresp  <= RESP_OKAY;
    end else if (rd_en) begin
      s_axi4l_rvalid <= 1'b1;
      s_axi4l_rdata  <= rd_data;
      s_axi4l_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi4l_rready) begin
      s_axi4l_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/eval_core_ctrl_axi4l.sv
// Control/status registers for the add512 eval core: start pulse, size, busy/done, run-cycle count.
// Latency: register writes take effect at the commit edge; core_start pulses for the cycle after it.
// Backpressure: inherited from the AXI4-Lite front end; core_done is never stalled.
module eval_core_ctrl_axi4l
  import eval_core_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 40,
  parameter int          DATA_WIDTH = 64,
  parameter int          SIZE_WIDTH = 32,
  parameter int          CNT_WIDTH  = 64,
  parameter logic [63:0] CORE_ID    = 64'h0000_0000_ADD5_1208
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic [ADDR_WIDTH-1:0]   s_axi4l_awaddr,
  input  logic [2:0]              s_axi4l_awprot,
  input  logic                    s_axi4l_awvalid,
  output logic                    s_axi4l_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi4l_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi4l_wstrb,
  input  logic                    s_axi4l_wvalid,
  output logic                    s_axi4l_wready,
  output logic [1:0]              s_axi4l_bresp,
  output logic                    s_axi4l_bvalid,
  input  logic                    s_axi4l_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi4l_araddr,
  input  logic [2:0]              s_axi4l_arprot,
  input  logic                    s_axi4l_arvalid,
  output logic                    s_axi4l_arready,
  output logic [DATA_WIDTH-1:0]   s_axi4l_rdata,
  output logic [1:0]              s_axi4l_rresp,
  output logic                    s_axi4l_rvalid,
  input  logic                    s_axi4l_rready,
  output logic                    core_start,
  output logic [SIZE_WIDTH-1:0]   core_size,
  input  logic                    core_done
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                    wr_en, rd_en, rd_err;
  logic [2:0]              wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   wr_data, rd_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;

  state_t                  state_q, state_d;
  logic [SIZE_WIDTH-1:0]   size_q;
  logic [CNT_WIDTH-1:0]    count_q;
  logic                    done_q;
  logic                    start_take, done_clr;

  // Only the low SIZE_WIDTH data bits and their strobes reach any register.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{rd_en, wr_data[DATA_WIDTH-1:SIZE_WIDTH],
                            wr_strb[DATA_WIDTH/8-1:SIZE_WIDTH/8]};

  eval_core_ctrl_axi4l_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if (
    .clk             (clk),
    .reset           (reset),
    .s_axi4l_awaddr  (s_axi4l_awaddr),
    .s_axi4l_awprot  (s_axi4l_awprot),
    .s_axi4l_awvalid (s_axi4l_awvalid),
    .s_axi4l_awready (s_axi4l_awready),
    .s_axi4l_wdata   (s_axi4l_wdata),
    .s_axi4l_wstrb   (s_axi4l_wstrb),
    .s_axi4l_wvalid  (s_axi4l_wvalid),
    .s_axi4l_wready  (s_axi4l_wready),
    .s_axi4l_bresp   (s_axi4l_bresp),
    .s_axi4l_bvalid  (s_axi4l_bvalid),
    .s_axi4l_bready  (s_axi4l_bready),
    .s_axi4l_araddr  (s_axi4l_araddr),
    .s_axi4l_arprot  (s_axi4l_arprot),
    .s_axi4l_arvalid (s_axi4l_arvalid),
    .s_axi4l_arready (s_axi4l_arready),
    .s_axi4l_rdata   (s_axi4l_rdata),
    .s_axi4l_rresp   (s_axi4l_rresp),
    .s_axi4l_rvalid  (s_axi4l_rvalid),
    .s_axi4l_rready  (s_axi4l_rready),
    .wr_en           (wr_en),
    .wr_idx          (wr_idx),
    .wr_data         (wr_data),
    .wr_strb         (wr_strb),
    .rd_en           (rd_en),
    .rd_idx          (rd_idx),
    .rd_data         (rd_data),
    .rd_err          (rd_err)
  );

  // A start only counts from IDLE; repeats while running are swallowed.
  assign start_take = wr_en && (wr_idx == ADR_CONTROL) && wr_strb[0] && wr_data[0]
                      && (state_q == ST_IDLE);
  assign done_clr   = wr_en && (wr_idx == ADR_STATUS) && wr_strb[0] && wr_data[1];
  assign core_size  = size_q;

  // Control FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Control FSM next state: IDLE waits for a start, RUN waits for core_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_take) state_d = ST_RUN;
      ST_RUN:  if (core_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One-cycle start pulse following the accepted CONTROL write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) core_start <= 1'b0;
    else       core_start <= start_take;
  end

  // Run-cycle counter: cleared on start, saturating count of non-done RUN edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (start_take) begin
      count_q <= '0;
    end else if ((state_q == ST_RUN) && !core_done && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Sticky done flag; a completion beats a same-edge software clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if ((state_q == ST_RUN) && core_done) begin
      done_q <= 1'b1;
    end else if (start_take || done_clr) begin
      done_q <= 1'b0;
    end
  end

  // SIZE register with per-byte strobes; writable at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q <= '0;
    end else if (wr_en && (wr_idx == ADR_SIZE)) begin
      for (int i = 0; i < SIZE_WIDTH; i++) begin
        if (wr_strb[i/8]) size_q[i] <= wr_data[i];
      end
    end
  end

  // Read mux over current register state; unmapped words return zero with an error.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      ADR_ID:      rd_data = DATA_WIDTH'(CORE_ID);
      ADR_CONTROL: rd_data = '0;
      ADR_STATUS:  rd_data = {{(DATA_WIDTH-2){1'b0}}, done_q, (state_q == ST_RUN)};
      ADR_SIZE:    rd_data = DATA_WIDTH'(size_q);
      ADR_CYCLES:  rd_data = DATA_WIDTH'(count_q);
      default:     rd_err  = 1'b1;
    endcase
  end

endmodule

// File: doc/eval_core_ctrl_axi4l.md
Name: eval_core_ctrl_axi4l

Overview:
- AXI4-Lite slave control/status register block consuming the 64-bit AXI4-Lite master port driven by the Wishbone-to-AXI4L bridge.
- Starts the eval core (add512 SRAM-to-SRAM) with a one-cycle start pulse and a size register.
- Tracks busy/done and counts core run cycles.
- Single clock domain: core and register bus share one clock.

Parameters:
ADDR_WIDTH, 40, AXI4-Lite address width
DATA_WIDTH, 64, AXI4-Lite data width (fixed 64; strobe width DATA_WIDTH/8)
SIZE_WIDTH, 32, width of core_size
CNT_WIDTH, 64, width of cycle counter
CORE_ID, 64'h0000_0000_ADD5_1208, value of ID register

Ports:
reset  in  1  asynchronous, active-high reset
clk  in  1  single clock for bus and core
s_axi4l_awaddr  in  ADDR_WIDTH  write address
s_axi4l_awprot  in  3  ignored
s_axi4l_awvalid  in  1  write address valid
s_axi4l_awready  out  1  write address ready
s_axi4l_wdata  in  64  write data
s_axi4l_wstrb  in  8  byte strobes
s_axi4l_wvalid  in  1  write data valid
s_axi4l_wready  out  1  write data ready
s_axi4l_bresp  out  2  write response
s_axi4l_bvalid  out  1  write response valid
s_axi4l_bready  in  1  write response ready
s_axi4l_araddr  in  ADDR_WIDTH  read address
s_axi4l_arprot  in  3  ignored
s_axi4l_arvalid  in  1  read address valid
s_axi4l_arready  out  1  read address ready
s_axi4l_rdata  out  64  read data
s_axi4l_rresp  out  2  read response
s_axi4l_rvalid  out  1  read data valid
s_axi4l_rready  in  1  read data ready
core_start  out  1  one-cycle start pulse
core_size  out  SIZE_WIDTH  element count for core
core_done  in  1  one-cycle completion pulse from core

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - core_start=0, core_size=0, count=0, done=0.
  - State IDLE.
- Register map (word index = addr[5:3]; addr[2:0] ignored; addr bits above [5] ignored):
  - 0x00 ID, RO: CORE_ID.
  - 0x08 CONTROL, WO: bit0 start; reads 0.
  - 0x10 STATUS: bit0 busy (RO), bit1 done (sticky; write 1 to bit1 clears); others read 0.
  - 0x18 SIZE, RW: low SIZE_WIDTH bits, byte-strobed.
  - 0x20 CYCLES, RO: cycle counter.
  - Index 5..7 unmapped: reads return 0 with SLVERR (2'b10); writes are dropped with SLVERR. Mapped accesses return OKAY.
- Write channel:
  - AW and W are captured independently into holding registers.
  - awready = !aw_held; wready = !w_held.
  - When both are held and (!bvalid || bready): commit at that edge, clear both holds, bvalid=1 and bresp set at the same edge.
  - Latency: AW/W both accepted at edge N → commit and bvalid high after edge N+1.
  - bvalid holds until bready. No new commit while bvalid && !bready.
- Read channel:
  - arready = !rvalid.
  - At the AR handshake edge, rdata/rresp are registered from current state and rvalid=1.
  - rdata/rresp are held stable until rready.
  - Read and write may complete in the same cycle. A read in the commit cycle returns the pre-commit value.
- Strobes: only SIZE honours byte strobes. CONTROL start requires wstrb[0]. STATUS clear requires wstrb[0].
- Control FSM:
  - IDLE: a CONTROL commit with wdata[0]=1 does three things at that edge: core_start=1 for exactly one cycle, count cleared to 0, state → RUN.
  - RUN: count increments each edge where core_done=0, saturating at all-ones. At an edge with core_done=1: state → IDLE, done=1, count not incremented.
  - Result: if start is high in cycle S and done is high in cycle S+k, CYCLES=k.
  - Start written while in RUN is ignored: no pulse, count unaffected. bresp is still OKAY.
  - core_done while IDLE is ignored.
- busy reads 1 exactly in RUN.
- done is cleared at the edge a start is taken.
- Simultaneous core_done and done-clear write: set wins, done=1.
- core_size = SIZE register; writes to SIZE while in RUN are still applied.
- Asynchronous reset mid-transaction:
  - Drops all held AW/W and pending B/R.
  - FSM → IDLE, core_start deasserts immediately.

Decomposition:
- Package eval_core_ctrl_pkg holds:
  - Register word-index constants (ADR_ID=0, ADR_CONTROL=1, ADR_STATUS=2, ADR_SIZE=3, ADR_CYCLES=4).
  - Response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - State enum {ST_IDLE, ST_RUN}.
- One sub-module, eval_core_ctrl_axi4l_if: AXI4-Lite handshake, holding registers and B/R channels. It presents a one-cycle wr_en/wr_idx/wr_data/wr_strb and rd_en/rd_idx with combinational rd_data/rd_err return.
- The top holds the register file and FSM.

Test Plan:
1. Reset → awready=wready=arready=1, bvalid=rvalid=0, core_start=0. Read 0x00 → rdata=CORE_ID, rresp=0; rvalid one cycle after the AR handshake.
2. Write SIZE=0x1234 with wstrb=8'h03, then wstrb=8'h0C, data 0x5678_0000 → read 0x18 = 0x5678_1234. Independently: AW two cycles before W → single commit, bvalid one cycle after the W handshake.
3. Write CONTROL=1 → core_start high one cycle, STATUS=0x1. Bench pulses core_done 10 cycles after start → STATUS=0x2, CYCLES=10.
4. Write CONTROL=1 in RUN → no core_start pulse, CYCLES unaffected, bresp=OKAY. Write STATUS=0x2 in the same cycle as a core_done pulse → STATUS reads 0x2. A later STATUS=0x2 write → 0x0.
5. Read and write address 0x28 → rresp=SLVERR, rdata=0, bresp=SLVERR, no register changes. Hold bready=0 for 5 cycles → bvalid stays 1, awready stays 0 after the next AW is captured.
6. Assert reset during RUN with bvalid pending → bvalid=0, STATUS=0, core_start=0 immediately. Post-reset write/read to SIZE completes normally.
